// File: rtl/alu_issue.sv
// alu_issue: in-order-preference issue buffer feeding the ALU exeparam interface.
// Holds up to DP renamed micro-ops in a compacting queue (entry 0 oldest), checks
// operand readiness against the live writeback log and issues the oldest ready
// micro-op through registered vaild/packet outputs.
module alu_issue #(
  parameter int RN = 6,                // physical register index width
  parameter int RP = 2,                // writeback log is 32*RP bits
  parameter int DW = 128 + 3 * RN + 4, // micro-op packet width (flags in the MSBs)
  parameter int DP = 4                 // buffer depth (2..8)
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            flush,
  input  logic            alu_dispat_vaild,
  input  logic [DW-1:0]   alu_dispat_info,
  output logic            alu_buffer_full,
  input  logic [32*RP-1:0] wbLog_qout,
  output logic            alu_exeparam_vaild,
  output logic [DW-1:0]   alu_exeparam
);

  localparam int CW = $clog2(DP + 1);
  localparam int IW = $clog2(DP);
  localparam int RS2_LSB = 128 + RN;
  localparam int RS1_LSB = 128 + 2 * RN;

  logic [DW-1:0] entry_reg  [DP];
  logic [DW-1:0] entry_next [DP];
  logic [DP-1:0] valid_reg;
  logic [DP-1:0] valid_next;
  logic [DP-1:0] ready;
  logic          full_reg;
  logic          full_next;
  logic          vaild_reg;
  logic [DW-1:0] param_reg;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] count;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Per-entry readiness: register index 0 is a hardwired zero and never waits.
  generate
    for (genvar gi = 0; gi < DP; gi++) begin : g_ready
      logic [RN-1:0] rs1;
      logic [RN-1:0] rs2;
      assign rs1 = entry_reg[gi][RS1_LSB +: RN];
      assign rs2 = entry_reg[gi][RS2_LSB +: RN];
      assign ready[gi] = valid_reg[gi]
                       & ((rs1 == '0) | wbLog_qout[rs1])
                       & ((rs2 == '0) | wbLog_qout[rs2]);
    end
  endgenerate

  // Oldest-ready select and occupancy count.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    count     = '0;
    for (int e = DP - 1; e >= 0; e--) begin
      if (ready[e]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(e);
      end
    end
    for (int e = 0; e < DP; e++) begin
      count = count + CW'(valid_reg[e]);
    end
  end

  // Next queue state: compact out the issued entry, then append the dispatch.
  always_comb begin
    entry_next = entry_reg;
    valid_next = valid_reg;
    accept     = alu_dispat_vaild & ~full_reg & ~flush;
    wr_idx     = count - CW'(sel_found);
    if (sel_found) begin
      for (int e = 0; e < DP - 1; e++) begin
        if (IW'(e) >= sel_idx) begin
          entry_next[e] = entry_reg[e + 1];
          valid_next[e] = valid_reg[e + 1];
        end
      end
      valid_next[DP-1] = 1'b0;
    end
    if (accept) begin
      for (int e = 0; e < DP; e++) begin
        if (wr_idx == CW'(e)) begin
          entry_next[e] = alu_dispat_info;
          valid_next[e] = 1'b1;
        end
      end
    end
    cnt_next  = count - CW'(sel_found) + CW'(accept);
    full_next = (cnt_next == CW'(DP));
  end

  // Control state and registered issue outputs; flush wins over issue/dispatch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_reg <= '0;
      full_reg  <= 1'b0;
      vaild_reg <= 1'b0;
      param_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
      full_reg  <= 1'b0;
      vaild_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      full_reg  <= full_next;
      vaild_reg <= sel_found;
      if (sel_found) begin
        param_reg <= entry_reg[sel_idx];
      end
    end
  end

  // Payload storage; qualified by valid_reg so it needs no reset.
  always_ff @(posedge CLK) begin
    entry_reg <= entry_next;
  end

  assign alu_buffer_full    = full_reg;
  assign alu_exeparam_vaild = vaild_reg;
  assign alu_exeparam       = param_reg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scenarios plus a randomized phase, all checked against a
// queue-based reference model of the issue buffer.
module tb_alu_issue;

  localparam int RN = 6;
  localparam int RP = 2;
  localparam int DW = 128 + 3 * RN + 4;
  localparam int DP = 4;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            flush = 1'b0;
  logic            dvld = 1'b0;
  logic [DW-1:0]   dinfo = '0;
  logic            full;
  logic [32*RP-1:0] wb = '0;
  logic            ovld;
  logic [DW-1:0]   opkt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] q[$];
  logic          exp_vld  = 1'b0;
  logic          exp_full = 1'b0;
  logic [DW-1:0] exp_pkt  = '0;

  alu_issue #(.RN(RN), .RP(RP), .DW(DW), .DP(DP)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .alu_dispat_vaild(dvld), .alu_dispat_info(dinfo),
    .alu_buffer_full(full), .wbLog_qout(wb),
    .alu_exeparam_vaild(ovld), .alu_exeparam(opkt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int rs1, input int rs2, input int rd);
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i += 32) p[i +: 32] = $urandom;
    p[128 +: RN]          = RN'(rd);
    p[128 + RN +: RN]     = RN'(rs2);
    p[128 + 2 * RN +: RN] = RN'(rs1);
    return p;
  endfunction

  function automatic bit op_ready(input logic [DW-1:0] p);
    int r1, r2;
    r1 = int'(p[128 + 2 * RN +: RN]);
    r2 = int'(p[128 + RN +: RN]);
    return (r1 == 0 || wb[r1]) && (r2 == 0 || wb[r2]);
  endfunction

  // one clock: drive inputs, advance the model, compare outputs after the edge
  task automatic step(input logic f, input logic dv, input logic [DW-1:0] info, input string tag);
    int idx;
    @(negedge CLK);
    flush = f; dvld = dv; dinfo = info;
    if (f) begin
      q.delete();
      exp_vld  = 1'b0;
      exp_full = 1'b0;
    end else begin
      idx = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (idx < 0 && op_ready(q[i])) idx = i;
      end
      exp_vld = (idx >= 0);
      if (idx >= 0) begin
        exp_pkt = q[idx];
        q.delete(idx);
      end
      if (dv) begin
        if (exp_full) $display("note: %s dispatch offered while full (protocol error, ignored)", tag);
        else q.push_back(info);
      end
      exp_full = (q.size() == DP);
    end
    @(posedge CLK);
    #1;
    chk({tag, ".vaild"}, DW'(ovld), DW'(exp_vld));
    chk({tag, ".full"}, DW'(full), DW'(exp_full));
    chk({tag, ".pkt"}, opkt, exp_pkt);
    if (ovld) $display("%s: issue rs1=%0d rs2=%0d rd=%0d", tag,
                       opkt[128 + 2 * RN +: RN], opkt[128 + RN +: RN], opkt[128 +: RN]);
    flush = 1'b0; dvld = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, tag);
  endtask

  logic [DW-1:0] pa, pb, pt;
  int seen;

  initial begin
    // reset
    #12;
    chk("rst.vaild", DW'(ovld), '0);
    chk("rst.full", DW'(full), '0);
    chk("rst.pkt", opkt, '0);
    @(negedge CLK); RSTn = 1'b1;

    // 1: ready op, two-cycle latency, bit-exact packet
    wb[3] = 1'b1;
    pa = mk(3, 0, 9);
    step(1'b0, 1'b1, pa, "t1.disp");
    chk("t1.c1_vaild", DW'(ovld), '0);
    idle(1, "t1.c2");
    chk("t1.c2_pkt", opkt, pa);
    idle(2, "t1.c3");

    // 2: younger ready op overtakes an older waiting one
    pa = mk(5, 0, 10);
    pb = mk(0, 0, 11);
    step(1'b0, 1'b1, pa, "t2.dispA");
    step(1'b0, 1'b1, pb, "t2.dispB");
    idle(1, "t2.issB");
    chk("t2.B_first", opkt, pb);
    wb[5] = 1'b1;
    idle(1, "t2.issA");
    chk("t2.A_next", opkt, pa);
    idle(2, "t2.nodup");

    // 3: fill to full, release, drain in order
    for (int i = 0; i < DP; i++) step(1'b0, 1'b1, mk(7, 0, 20 + i), "t3.fill");
    chk("t3.full", DW'(full), 1);
    wb[7] = 1'b1;
    seen = 0;
    for (int i = 0; i < DP; i++) begin
      idle(1, "t3.drain");
      if (ovld && opkt[128 +: RN] == RN'(20 + i)) seen++;
    end
    total++;
    assert (seen == DP) else begin
      bad++;
      $error("FAIL t3.order observed=%0d expected=%0d", seen, DP);
    end

    // 4: full with a same-cycle issue: offer ignored, accepted next cycle
    for (int i = 0; i < DP; i++) step(1'b0, 1'b1, mk(8, 0, 30 + i), "t4.fill");
    wb[8] = 1'b1;
    pt = mk(0, 0, 40);
    step(1'b0, 1'b1, pt, "t4.offer_full");
    step(1'b0, 1'b1, pt, "t4.offer_ok");
    idle(6, "t4.drain");

    // 5: flush with pending entries and a same-cycle dispatch
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(12, 13, 50 + i), "t5.fill");
    step(1'b1, 1'b1, mk(0, 0, 60), "t5.flush");
    wb = '0;
    wb[12] = 1'b1; wb[13] = 1'b1;
    idle(3, "t5.after");

    // 6: asynchronous reset mid-stream
    wb = '0;
    step(1'b0, 1'b1, mk(0, 0, 1), "t6.disp");
    step(1'b0, 1'b1, mk(14, 0, 2), "t6.disp2");
    #2 RSTn = 1'b0;
    #1;
    chk("t6.rst_vaild", DW'(ovld), '0);
    chk("t6.rst_full", DW'(full), '0);
    chk("t6.rst_pkt", opkt, '0);
    q.delete(); exp_vld = 1'b0; exp_full = 1'b0; exp_pkt = '0;
    @(negedge CLK); RSTn = 1'b1;
    wb[3] = 1'b1;
    pa = mk(3, 0, 9);
    step(1'b0, 1'b1, pa, "t6.redisp");
    idle(1, "t6.c1");
    chk("t6.c2_pkt", opkt, pa);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) wb[$urandom_range(1, 15)] = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)), mk($urandom_range(0, 15), 0, 0), "rnd.flush");
        wb = '0;
      end else if ($urandom_range(0, 2) != 0 && !exp_full) begin
        step(1'b0, 1'b1, mk($urandom_range(0, 15), $urandom_range(0, 15), c & 63), "rnd.disp");
      end else begin
        step(1'b0, 1'b0, '0, "rnd.idle");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
